mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the MIPS CPU. It replaces single-cycle opcode decode with a Moore state machine that steps the shared datapath (one memory port, one ALU, register file, PC) through fetch, decode, execute, memory and write-back. It also handles memory wait states and traps illegal opcodes. It sits beside the datapath and drives every enable and mux select.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26]; stable from DECODE until the next IR write
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current request this cycle
- pc_we, ir_we, mem_read, mem_write, reg_write  out  1 each  enables
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_dst  out  1  register destination: 1 = rd, 0 = rt
- mem_to_reg  out  1  write-back data: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- halt  out  1  illegal-instruction trap
- state  out  4  current state, for debug and coverage

## Operation
- All outputs are combinational functions of state, plus zero, mem_ready and opcode where noted. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_we = pc_we = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch:
  - opcode 000000 with funct 100000 → EXEC_R
  - 001000 → EXEC_I
  - 100011 or 101011 → MEM_ADDR
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - anything else, including R-type with another funct → HALT
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1. Next is FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next is I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next is FETCH.
- MEM_ADDR: same ALU controls as EXEC_I. Next is MEM_RD for 100011, MEM_WR for 101011.
- MEM_RD: mem_read=1, i_or_d=1. Stays until mem_ready, then goes to LW_WB.
- LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1, retire=mem_ready. Stays until mem_ready, then goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, retire=1. Next is FETCH.
  - beq: pc_we = zero.
  - bne: pc_we = ~zero.
- JUMP: pc_src=10, pc_we=1, retire=1. Next is FETCH.
- HALT: halt=1, all other outputs 0. Held until reset.

## Timing
- Reset: on rst_n low, state goes to IDLE immediately, without waiting for a clock. All outputs are 0 while rst_n is low, including any in-flight mem_write or mem_read.
- Reset mid-access: the aborted access is dropped; no retry after reset.
- First fetch: FETCH is entered on the first rising edge after rst_n deasserts.
- Instruction cycles with zero-wait memory: add 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- Wait states: each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request outputs are held constant while waiting.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- retire fires exactly once per legal instruction and never in HALT.
- pc_we never fires in the same cycle as reg_write.
- mem_read and mem_write are never both 1.

## Structure
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit): IDLE, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD, LW_WB, MEM_WR, BRANCH, JUMP, HALT
  - opcode and funct constants
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, mc_opdecode: combinational classification of opcode and funct into R/ADDI/LW/SW/BEQ/BNE/J/ILLEGAL. It is reused by the future ALU-control block.

## Test plan
- Reset and first fetch: hold rst_n=0 for 3 cycles, then release. Required: all outputs 0 during reset; IDLE, then FETCH with mem_read=1, i_or_d=0, alu_src_b=01.
- add with zero-wait memory (opcode 000000, funct 100000, mem_ready=1): state FETCH→DECODE→EXEC_R→R_WB; reg_write=1 with reg_dst=1 in cycle 4; one retire pulse.
- lw with 2 wait cycles on the data read: MEM_RD held 3 cycles with mem_read=1 and i_or_d=1; LW_WB has mem_to_reg=1; total 7 cycles.
- beq and bne, each run with zero=1 and zero=0:
  - beq with zero=1 → pc_we=1 and pc_src=01 in BRANCH.
  - bne with zero=1 → pc_we=0.
  - Both complete in 3 cycles.
- Illegal opcode 111111, and opcode 000000 with funct 100010 → HALT after DECODE; halt stays 1 for 10+ cycles and no retire; then rst_n pulse → IDLE.
- Asynchronous reset asserted mid-MEM_WR with mem_ready=0: mem_write drops to 0 in the same cycle, without a clock edge; after release the sequence restarts at FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: sequencer states,
// opcode/funct constants, instruction classes and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_LW_WB    = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] FN_ADD    = 6'b100000;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_BNE     = 3'd5,
        CLS_J       = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_e;

    localparam logic [1:0] ALU_ADD      = 2'b00;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_FUNCT    = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational classification of opcode/funct into instruction classes.
// Any R-type other than add is treated as illegal.
module mc_opdecode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_e  op_class
);

    // Opcode/funct to instruction class lookup
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_RTYPE: begin
                if (funct == FN_ADD) begin
                    op_class = CLS_R;
                end else begin
                    op_class = CLS_ILLEGAL;
                end
            end
            OPC_ADDI: op_class = CLS_ADDI;
            OPC_LW:   op_class = CLS_LW;
            OPC_SW:   op_class = CLS_SW;
            OPC_BEQ:  op_class = CLS_BEQ;
            OPC_BNE:  op_class = CLS_BNE;
            OPC_J:    op_class = CLS_J;
            default:  op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle Moore control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back, absorbs memory waits, traps illegals.
module mc_sequencer
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       halt,
    output logic [3:0] state
);

    state_e    state_r;
    state_e    next_state_s;
    op_class_e op_class_s;
    ctrl_t     ctrl_s;

    mc_opdecode u_opdecode (
        .opcode   (opcode),
        .funct    (funct),
        .op_class (op_class_s)
    );

    // State register; reset drops any in-flight access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op_class_s)
                    CLS_R:             next_state_s = ST_EXEC_R;
                    CLS_ADDI:          next_state_s = ST_EXEC_I;
                    CLS_LW, CLS_SW:    next_state_s = ST_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:  next_state_s = ST_BRANCH;
                    CLS_J:             next_state_s = ST_JUMP;
                    default:           next_state_s = ST_HALT;
                endcase
            end
            ST_EXEC_R: next_state_s = ST_R_WB;
            ST_R_WB:   next_state_s = ST_FETCH;
            ST_EXEC_I: next_state_s = ST_I_WB;
            ST_I_WB:   next_state_s = ST_FETCH;
            ST_MEM_ADDR: begin
                if (op_class_s == CLS_LW) begin
                    next_state_s = ST_MEM_RD;
                end else if (op_class_s == CLS_SW) begin
                    next_state_s = ST_MEM_WR;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    next_state_s = ST_LW_WB;
                end else begin
                    next_state_s = ST_MEM_RD;
                end
            end
            ST_LW_WB:  next_state_s = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_BRANCH: next_state_s = ST_FETCH;
            ST_JUMP:   next_state_s = ST_FETCH;
            ST_HALT:   next_state_s = ST_HALT;
            // Unused encodings trap rather than resume execution
            default:   next_state_s = ST_HALT;
        endcase
    end

    // Per-state datapath controls; anything unassigned stays 0
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            ST_IDLE: ctrl_s = '0;
            ST_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.i_or_d    = 1'b0;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                ctrl_s.pc_src    = PCSRC_ALU;
                ctrl_s.ir_we     = mem_ready;
                ctrl_s.pc_we     = mem_ready;
            end
            ST_DECODE: begin
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_IMM_SH2;
                ctrl_s.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.retire    = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALU_ADD;
            end
            ST_I_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.retire    = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.i_or_d   = 1'b1;
            end
            ST_LW_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.retire     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.i_or_d    = 1'b1;
                ctrl_s.retire    = mem_ready;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_SUB;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
                ctrl_s.retire    = 1'b1;
                if (op_class_s == CLS_BEQ) begin
                    ctrl_s.pc_we = zero;
                end else if (op_class_s == CLS_BNE) begin
                    ctrl_s.pc_we = ~zero;
                end else begin
                    ctrl_s.pc_we = 1'b0;
                end
            end
            ST_JUMP: begin
                ctrl_s.pc_src = PCSRC_JUMP;
                ctrl_s.pc_we  = 1'b1;
                ctrl_s.retire = 1'b1;
            end
            ST_HALT: ctrl_s.halt = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    assign pc_we      = ctrl_s.pc_we;
    assign ir_we      = ctrl_s.ir_we;
    assign mem_read   = ctrl_s.mem_read;
    assign mem_write  = ctrl_s.mem_write;
    assign reg_write  = ctrl_s.reg_write;
    assign i_or_d     = ctrl_s.i_or_d;
    assign reg_dst    = ctrl_s.reg_dst;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign alu_src_a  = ctrl_s.alu_src_a;
    assign alu_src_b  = ctrl_s.alu_src_b;
    assign alu_op     = ctrl_s.alu_op;
    assign pc_src     = ctrl_s.pc_src;
    assign retire     = ctrl_s.retire;
    assign halt       = ctrl_s.halt;
    assign state      = state_r;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a per-instruction reference model
// expands each instruction into its expected cycle trace from the ISA rules.
module tb_mc_sequencer;
    import mips_ctrl_pkg::*;

    localparam int K_ADD = 0, K_ADDI = 1, K_LW = 2, K_SW = 3;
    localparam int K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

    typedef struct packed {
        logic       pc_we, ir_we, mem_read, mem_write, reg_write;
        logic       i_or_d, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       retire, halt;
    } exp_ctl_t;

    typedef struct packed {
        logic [3:0] st;
        exp_ctl_t   c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_read, mem_write, reg_write, i_or_d;
    logic       reg_dst, mem_to_reg, alu_src_a, retire, halt;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    exp_ctl_t   ctl_obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   bk;
    exp_t exp_q[$];
    logic rdy_a [0:63];
    logic zero_a[0:63];

    mc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .retire(retire), .halt(halt), .state(state)
    );

    assign ctl_obs = {pc_we, ir_we, mem_read, mem_write, reg_write, i_or_d, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire, halt};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h20) ? K_ADD : K_ILL;
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input exp_ctl_t c);
        exp_q.push_back({st, c});
        bk++;
    endtask

    // Expand one instruction into its expected per-cycle trace
    task automatic build(input int cls);
        exp_ctl_t c;
        logic     done;
        exp_q.delete();
        bk = 0;
        do begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            c.ir_we = rdy_a[bk]; c.pc_we = rdy_a[bk];
            done = rdy_a[bk];
            push(ST_FETCH, c);
        end while (!done);
        c = '0; c.alu_src_b = 2'b11;
        push(ST_DECODE, c);
        case (cls)
            K_ADD: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = 2'b10;
                push(ST_EXEC_R, c);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1;
                push(ST_R_WB, c);
            end
            K_ADDI: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(ST_EXEC_I, c);
                c = '0; c.reg_write = 1'b1; c.retire = 1'b1;
                push(ST_I_WB, c);
            end
            K_LW, K_SW: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                push(ST_MEM_ADDR, c);
                do begin
                    c = '0; c.i_or_d = 1'b1;
                    if (cls == K_LW) c.mem_read = 1'b1;
                    else begin c.mem_write = 1'b1; c.retire = rdy_a[bk]; end
                    done = rdy_a[bk];
                    push((cls == K_LW) ? ST_MEM_RD : ST_MEM_WR, c);
                end while (!done);
                if (cls == K_LW) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1;
                    push(ST_LW_WB, c);
                end
            end
            K_BEQ, K_BNE: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                c.retire = 1'b1;
                c.pc_we = (cls == K_BEQ) ? zero_a[bk] : ~zero_a[bk];
                push(ST_BRANCH, c);
            end
            K_J: begin
                c = '0; c.pc_src = 2'b10; c.pc_we = 1'b1; c.retire = 1'b1;
                push(ST_JUMP, c);
            end
            default: begin
                for (int i = 0; i < 12; i++) begin
                    c = '0; c.halt = 1'b1;
                    push(ST_HALT, c);
                end
            end
        endcase
    endtask

    // Drive and check the first n cycles of the expected trace
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_ready = rdy_a[i];
            zero = zero_a[i];
            @(negedge clk);
            check_eq("state", 32'(state), 32'(exp_q[i].st));
            check_eq("ctrl", 32'(ctl_obs), 32'(exp_q[i].c));
            check_eq("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_state", 32'(state), 32'(ST_IDLE));
        check_eq("rst_async_ctrl", 32'(ctl_obs), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        check_eq("rst_held_ctrl", 32'(ctl_obs), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", 32'(state), 32'(ST_IDLE));
    endtask

    task automatic set_stim(input logic all_ready, input logic z);
        for (int i = 0; i < 64; i++) begin
            rdy_a[i]  = (all_ready || i >= 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            zero_a[i] = z;
        end
    endtask

    task automatic exec(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct = fn;
        build(classify(op, fn));
        run(exp_q.size());
        if (classify(op, fn) == K_ILL) reset_pulse();
    endtask

    initial begin
        logic [5:0] op, fn;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_state", 32'(state), 32'(ST_IDLE));
            check_eq("reset_ctrl", 32'(ctl_obs), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_idle", 32'(state), 32'(ST_IDLE));

        set_stim(1'b1, 1'b0); exec(6'h00, 6'h20);
        set_stim(1'b1, 1'b0); rdy_a[3] = 1'b0; rdy_a[4] = 1'b0; exec(6'h23, 6'h11);
        set_stim(1'b1, 1'b1); exec(6'h04, 6'h00);
        set_stim(1'b1, 1'b0); exec(6'h04, 6'h00);
        set_stim(1'b1, 1'b1); exec(6'h05, 6'h00);
        set_stim(1'b1, 1'b0); exec(6'h05, 6'h00);
        set_stim(1'b1, 1'b0); exec(6'h02, 6'h3f);
        set_stim(1'b1, 1'b0); exec(6'h3f, 6'h20);
        set_stim(1'b1, 1'b0); exec(6'h00, 6'h22);

        // Store stalled in MEM_WR, then reset asynchronously mid-cycle
        set_stim(1'b1, 1'b0);
        for (int i = 3; i < 10; i++) rdy_a[i] = 1'b0;
        opcode = 6'h2b; funct = 6'h00;
        build(K_SW);
        run(4);
        reset_pulse();
        set_stim(1'b1, 1'b0); exec(6'h08, 6'h05);

        for (int n = 0; n < 60; n++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 9))
                0, 7:    begin op = 6'h00; fn = 6'h20; end
                1:       op = 6'h08;
                2:       op = 6'h23;
                3:       op = 6'h2b;
                4:       op = 6'h04;
                5:       op = 6'h05;
                6:       op = 6'h02;
                default: op = 6'($urandom_range(0, 63));
            endcase
            set_stim(1'b0, 1'b0);
            for (int i = 0; i < 64; i++) zero_a[i] = 1'($urandom_range(0, 1));
            exec(op, fn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
